// File: rtl/simd_operand_loader.sv
// Packs (data, weight) pairs into SIMD vectors, double-buffers them in two slots and issues each
// vector to the MAC accelerator with a start/busy/result handshake.
module simd_operand_loader #(
  parameter int unsigned SIMD_LANES   = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              in_data,
  input  logic [WEIGHT_WIDTH-1:0]            in_weight,
  input  logic                               in_last,
  output logic [SIMD_LANES*DATA_WIDTH-1:0]   vec_data_out,
  output logic [SIMD_LANES*WEIGHT_WIDTH-1:0] vec_weight_out,
  output logic                               data_valid,
  output logic                               simd_start,
  input  logic                               accel_busy,
  input  logic                               accel_result_valid,
  output logic [1:0]                         fill_level,
  output logic [15:0]                        vectors_issued,
  output logic                               timeout_err
);

  localparam int unsigned VecDw = SIMD_LANES * DATA_WIDTH;
  localparam int unsigned VecWw = SIMD_LANES * WEIGHT_WIDTH;
  localparam int unsigned LaneW = (SIMD_LANES > 1) ? $clog2(SIMD_LANES) : 1;
  localparam int unsigned TmoW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(SIMD_LANES - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IssueIdle, IssueReq, IssueWait, IssueRelease} issue_state_e;

  issue_state_e     state_q, state_d;
  logic [VecDw-1:0] slot_data_q [2];
  logic [VecDw-1:0] slot_data_d [2];
  logic [VecWw-1:0] slot_weight_q [2];
  logic [VecWw-1:0] slot_weight_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [LaneW-1:0] lane_idx_q, lane_idx_d;
  logic [1:0]       count_q, count_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic             tmo_abort_q, tmo_abort_d;
  logic             data_valid_q, data_valid_d;
  logic             simd_start_q, simd_start_d;
  logic [15:0]      vectors_issued_q, vectors_issued_d;
  logic             timeout_err_q, timeout_err_d;

  logic accept;
  logic commit;
  logic release_slot;

  assign in_ready = enable & (count_q != 2'd2);

  always_comb begin
    state_d          = state_q;
    slot_data_d      = slot_data_q;
    slot_weight_d    = slot_weight_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    lane_idx_d       = lane_idx_q;
    count_d          = count_q;
    tmo_cnt_d        = tmo_cnt_q;
    tmo_abort_d      = tmo_abort_q;
    data_valid_d     = data_valid_q;
    simd_start_d     = simd_start_q;
    vectors_issued_d = vectors_issued_q;
    timeout_err_d    = timeout_err_q;

    accept       = in_valid & in_ready;
    commit       = accept & (in_last | (lane_idx_q == LastLane));
    release_slot = (state_q == IssueRelease);

    // Lanes above the closing lane are cleared so stale data from the slot's last use never leaks.
    if (accept) begin
      for (int l = 0; l < int'(SIMD_LANES); l++) begin
        if (l == int'(lane_idx_q)) begin
          slot_data_d[wr_ptr_q][l*DATA_WIDTH +: DATA_WIDTH]       = in_data;
          slot_weight_d[wr_ptr_q][l*WEIGHT_WIDTH +: WEIGHT_WIDTH] = in_weight;
        end else if (commit && (l > int'(lane_idx_q))) begin
          slot_data_d[wr_ptr_q][l*DATA_WIDTH +: DATA_WIDTH]       = '0;
          slot_weight_d[wr_ptr_q][l*WEIGHT_WIDTH +: WEIGHT_WIDTH] = '0;
        end
      end
      lane_idx_d = commit ? '0 : lane_idx_q + LaneW'(1);
      if (commit) begin
        wr_ptr_d = ~wr_ptr_q;
      end
    end

    case ({commit, release_slot})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IssueIdle: begin
        if (enable && (count_q != 2'd0)) begin
          state_d      = IssueReq;
          simd_start_d = 1'b1;
          data_valid_d = 1'b1;
        end
      end
      IssueReq: begin
        if (accel_busy) begin
          state_d      = IssueWait;
          simd_start_d = 1'b0;
        end
      end
      IssueWait: begin
        if (accel_result_valid) begin
          state_d      = IssueRelease;
          data_valid_d = 1'b0;
        end else if (tmo_cnt_q == TmoLast) begin
          state_d       = IssueRelease;
          data_valid_d  = 1'b0;
          timeout_err_d = 1'b1;
          tmo_abort_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      IssueRelease: begin
        state_d     = IssueIdle;
        rd_ptr_d    = ~rd_ptr_q;
        tmo_cnt_d   = '0;
        tmo_abort_d = 1'b0;
        if (!tmo_abort_q) begin
          vectors_issued_d = vectors_issued_q + 16'd1;
        end
      end
      default: state_d = IssueIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IssueIdle;
      slot_data_q      <= '{default: '0};
      slot_weight_q    <= '{default: '0};
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      lane_idx_q       <= '0;
      count_q          <= 2'd0;
      tmo_cnt_q        <= '0;
      tmo_abort_q      <= 1'b0;
      data_valid_q     <= 1'b0;
      simd_start_q     <= 1'b0;
      vectors_issued_q <= 16'd0;
      timeout_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      slot_data_q      <= slot_data_d;
      slot_weight_q    <= slot_weight_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      lane_idx_q       <= lane_idx_d;
      count_q          <= count_d;
      tmo_cnt_q        <= tmo_cnt_d;
      tmo_abort_q      <= tmo_abort_d;
      data_valid_q     <= data_valid_d;
      simd_start_q     <= simd_start_d;
      vectors_issued_q <= vectors_issued_d;
      timeout_err_q    <= timeout_err_d;
    end
  end

  // The read slot cannot be written while in flight: the writer only targets it when count is 2.
  assign vec_data_out   = data_valid_q ? slot_data_q[rd_ptr_q] : '0;
  assign vec_weight_out = data_valid_q ? slot_weight_q[rd_ptr_q] : '0;
  assign data_valid     = data_valid_q;
  assign simd_start     = simd_start_q;
  assign fill_level     = count_q;
  assign vectors_issued = vectors_issued_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_simd_operand_loader.sv
// Self-checking bench for simd_operand_loader: a pair-stream driver, an accelerator model, an
// issue monitor and a queue-based packing model.
module tb_simd_operand_loader;

  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned WW    = 8;
  localparam int unsigned TMO   = 64;
  localparam int unsigned VDW   = LANES * DW;
  localparam int unsigned VWW   = LANES * WW;

  logic           clk = 1'b0;
  logic           rst_n, enable, in_valid, in_last, accel_busy, accel_result_valid;
  logic           in_ready, data_valid, simd_start, timeout_err;
  logic [DW-1:0]  in_data;
  logic [WW-1:0]  in_weight;
  logic [VDW-1:0] vec_data_out;
  logic [VWW-1:0] vec_weight_out;
  logic [1:0]     fill_level;
  logic [15:0]    vectors_issued;

  simd_operand_loader #(
    .SIMD_LANES  (LANES),
    .DATA_WIDTH  (DW),
    .WEIGHT_WIDTH(WW),
    .TIMEOUT     (TMO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_weight         (in_weight),
    .in_last           (in_last),
    .vec_data_out      (vec_data_out),
    .vec_weight_out    (vec_weight_out),
    .data_valid        (data_valid),
    .simd_start        (simd_start),
    .accel_busy        (accel_busy),
    .accel_result_valid(accel_result_valid),
    .fill_level        (fill_level),
    .vectors_issued    (vectors_issued),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Packing model: expected vectors in issue order.
  logic [VDW-1:0] exp_d_q[$];
  logic [VWW-1:0] exp_w_q[$];
  logic [VDW-1:0] cur_d = '0;
  logic [VWW-1:0] cur_w = '0;
  int cur_lane   = 0;
  int exp_issued = 0;

  // Issue monitor.
  logic [VDW-1:0] obs_d_q[$];
  logic [VWW-1:0] obs_w_q[$];
  logic [VDW-1:0] last_obs_d = '0;
  logic [VWW-1:0] last_obs_w = '0;
  logic prev_start = 1'b0;
  int last_start_len = 0;
  int last_wait_len  = 0;
  int zero_viol      = 0;
  int stab_viol      = 0;

  // Driver statistics.
  int drv_timeouts = 0;
  int accepted     = 0;
  int stall_at     = -1;
  bit stalled_once = 1'b0;
  bit resumed_once = 1'b0;
  logic [1:0]  stall_fill, resume_fill;
  logic [15:0] resume_issued;
  logic        resume_dv;

  // Accelerator model; res_delay 0 means the result never arrives.
  int res_delay = 6;
  int acc_cnt   = 0;
  bit acc_active = 1'b0;

  initial begin
    accel_busy = 1'b0;
    accel_result_valid = 1'b0;
    forever begin
      @(negedge clk);
      accel_result_valid = 1'b0;
      if (rst_n !== 1'b1) begin
        accel_busy = 1'b0;
        acc_active = 1'b0;
      end else if (simd_start === 1'b1) begin
        accel_busy = 1'b1;
        acc_active = 1'b1;
        acc_cnt    = res_delay;
      end else if (acc_active && acc_cnt > 0) begin
        acc_cnt--;
        if (acc_cnt == 0) begin
          accel_result_valid = 1'b1;
          accel_busy         = 1'b0;
          acc_active         = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (simd_start === 1'b1 && prev_start !== 1'b1) begin
        obs_d_q.push_back(vec_data_out);
        obs_w_q.push_back(vec_weight_out);
        last_obs_d     = vec_data_out;
        last_obs_w     = vec_weight_out;
        last_start_len = 0;
        last_wait_len  = 0;
      end
      if (simd_start === 1'b1) last_start_len++;
      if (data_valid === 1'b1 && simd_start === 1'b0) last_wait_len++;
      if (data_valid === 1'b0 && (vec_data_out !== '0 || vec_weight_out !== '0)) zero_viol++;
      if (data_valid === 1'b1 && (vec_data_out !== last_obs_d || vec_weight_out !== last_obs_w))
        stab_viol++;
      prev_start = simd_start;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_accept(input logic [DW-1:0] d, input logic [WW-1:0] w, input logic last);
    cur_d = cur_d | (VDW'(d) << (DW * cur_lane));
    cur_w = cur_w | (VWW'(w) << (WW * cur_lane));
    cur_lane++;
    accepted++;
    if (last || cur_lane == int'(LANES)) begin
      exp_d_q.push_back(cur_d);
      exp_w_q.push_back(cur_w);
      cur_d    = '0;
      cur_w    = '0;
      cur_lane = 0;
    end
  endtask

  // Entered just after a negedge; returns at the negedge after the accepting edge.
  task automatic send_pair(input logic [DW-1:0] d, input logic [WW-1:0] w, input logic last);
    int n = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_weight = w;
    in_last   = last;
    while (!in_ready && n < 300) begin
      if (!stalled_once) begin
        stalled_once = 1'b1;
        stall_at     = accepted;
        stall_fill   = fill_level;
      end
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      drv_timeouts++;
    end else begin
      if (n > 0 && stalled_once && !resumed_once) begin
        resumed_once  = 1'b1;
        resume_fill   = fill_level;
        resume_issued = vectors_issued;
        resume_dv     = data_valid;
      end
      model_accept(d, w, last);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 600) begin
      @(negedge clk);
      n++;
      if (fill_level == 2'd0 && !data_valid && !simd_start) quiet++;
      else quiet = 0;
    end
    ok = (quiet >= 3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; in_weight = '0;
    repeat (3) @(negedge clk);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_dv got %b want 0", data_valid); end
    checks++; if (simd_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", simd_start); end
    checks++; if (vec_data_out !== '0) begin errors++; $display("FAIL rst_vdata got %h want 0", vec_data_out); end
    checks++; if (vec_weight_out !== '0) begin errors++; $display("FAIL rst_vweight got %h want 0", vec_weight_out); end
    checks++; if (fill_level !== 2'd0) begin errors++; $display("FAIL rst_fill got %0d want 0", fill_level); end
    checks++; if (vectors_issued !== 16'd0) begin errors++; $display("FAIL rst_issued got %0d want 0", vectors_issued); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_tmo got %b want 0", timeout_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_dis got %b want 0", in_ready); end
    rst_n = 1'b1; enable = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_en got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [VDW-1:0] ed, od;
    logic [VWW-1:0] ew, ow;
    res_delay = 6;
    for (int i = 0; i < 4; i++) send_pair(DW'(i + 1), WW'(i + 5), 1'b0);
    checks++; if (simd_start !== 1'b0) begin errors++; $display("FAIL basic_start_early got %b want 0", simd_start); end
    checks++; if (fill_level !== 2'd1) begin errors++; $display("FAIL basic_fill got %0d want 1", fill_level); end
    @(negedge clk);
    checks++; if (simd_start !== 1'b1 || data_valid !== 1'b1) begin
      errors++; $display("FAIL basic_start_lat got start=%b dv=%b want 1/1", simd_start, data_valid);
    end
    checks++; if (vec_data_out !== 32'h04030201 || vec_weight_out !== 32'h08070605) begin
      errors++; $display("FAIL basic_vec_const got %h/%h want 04030201/08070605", vec_data_out, vec_weight_out);
    end
    exp_issued++;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_idle got busy want idle"); end
    checks++; if (last_start_len !== 1) begin errors++; $display("FAIL basic_start_len got %0d want 1", last_start_len); end
    checks++; if (vectors_issued !== exp_issued[15:0]) begin
      errors++; $display("FAIL basic_issued got %0d want %0d", vectors_issued, exp_issued[15:0]);
    end
    checks++; if (obs_d_q.size() != exp_d_q.size()) begin
      errors++; $display("FAIL basic_count got %0d want %0d", obs_d_q.size(), exp_d_q.size());
    end
    while (obs_d_q.size() > 0 && exp_d_q.size() > 0) begin
      od = obs_d_q.pop_front(); ow = obs_w_q.pop_front();
      ed = exp_d_q.pop_front(); ew = exp_w_q.pop_front();
      checks++; if (od !== ed || ow !== ew) begin
        errors++; $display("FAIL basic_vec got %h/%h want %h/%h", od, ow, ed, ew);
      end
    end
    obs_d_q.delete(); obs_w_q.delete(); exp_d_q.delete(); exp_w_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    int base;
    logic [VDW-1:0] ed, od;
    logic [VWW-1:0] ew, ow;
    res_delay = 30; stalled_once = 1'b0; resumed_once = 1'b0; accepted = 0;
    base = exp_issued;
    for (int i = 0; i < 12; i++) send_pair(DW'($urandom), WW'($urandom), 1'b0);
    exp_issued += 3;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_idle got busy want idle"); end
    checks++; if (stall_at !== 8 || stall_fill !== 2'd2) begin
      errors++; $display("FAIL bp_stall got at=%0d fill=%0d want 8/2", stall_at, stall_fill);
    end
    checks++; if (!resumed_once || resume_fill !== 2'd1 || resume_issued !== 16'(base + 1) || resume_dv !== 1'b0) begin
      errors++; $display("FAIL bp_resume got fill=%0d issued=%0d dv=%b want 1/%0d/0",
                         resume_fill, resume_issued, resume_dv, base + 1);
    end
    checks++; if (vectors_issued !== exp_issued[15:0]) begin
      errors++; $display("FAIL bp_issued got %0d want %0d", vectors_issued, exp_issued[15:0]);
    end
    checks++; if (obs_d_q.size() != 3 || exp_d_q.size() != 3) begin
      errors++; $display("FAIL bp_count got %0d want 3 (model %0d)", obs_d_q.size(), exp_d_q.size());
    end
    while (obs_d_q.size() > 0 && exp_d_q.size() > 0) begin
      od = obs_d_q.pop_front(); ow = obs_w_q.pop_front();
      ed = exp_d_q.pop_front(); ew = exp_w_q.pop_front();
      checks++; if (od !== ed || ow !== ew) begin
        errors++; $display("FAIL bp_vec got %h/%h want %h/%h", od, ow, ed, ew);
      end
    end
    obs_d_q.delete(); obs_w_q.delete(); exp_d_q.delete(); exp_w_q.delete();
  endtask

  task automatic test_partial();
    bit ok;
    logic [VDW-1:0] ed, od;
    logic [VWW-1:0] ew, ow;
    res_delay = 6;
    send_pair(8'd9, 8'd3, 1'b0);
    send_pair(8'd10, 8'd4, 1'b1);
    exp_issued++;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL part_idle got busy want idle"); end
    checks++; if (obs_d_q.size() != 1) begin errors++; $display("FAIL part_count got %0d want 1", obs_d_q.size()); end
    if (obs_d_q.size() > 0) begin
      checks++; if (obs_d_q[0] !== 32'h00000A09 || obs_w_q[0] !== 32'h00000403) begin
        errors++; $display("FAIL part_vec_const got %h/%h want 00000a09/00000403", obs_d_q[0], obs_w_q[0]);
      end
    end
    while (obs_d_q.size() > 0 && exp_d_q.size() > 0) begin
      od = obs_d_q.pop_front(); ow = obs_w_q.pop_front();
      ed = exp_d_q.pop_front(); ew = exp_w_q.pop_front();
      checks++; if (od !== ed || ow !== ew) begin
        errors++; $display("FAIL part_vec got %h/%h want %h/%h", od, ow, ed, ew);
      end
    end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL part_tmo got %b want 0", timeout_err); end
    obs_d_q.delete(); obs_w_q.delete(); exp_d_q.delete(); exp_w_q.delete();
  endtask

  task automatic test_simultaneous();
    bit ok;
    int n = 0;
    logic [VDW-1:0] ed, od;
    logic [VWW-1:0] ew, ow;
    res_delay = 10;
    for (int i = 0; i < 4; i++) send_pair(DW'($urandom), WW'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) send_pair(DW'($urandom), WW'($urandom), 1'b0);
    while (!data_valid && n < 100) begin @(negedge clk); n++; end
    while (data_valid && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100 || fill_level !== 2'd1) begin
      errors++; $display("FAIL sim_release got n=%0d fill=%0d want release with fill 1", n, fill_level);
    end
    send_pair(DW'($urandom), WW'($urandom), 1'b0);
    checks++; if (fill_level !== 2'd1) begin errors++; $display("FAIL sim_fill got %0d want 1", fill_level); end
    exp_issued += 2;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sim_idle got busy want idle"); end
    checks++; if (vectors_issued !== exp_issued[15:0]) begin
      errors++; $display("FAIL sim_issued got %0d want %0d", vectors_issued, exp_issued[15:0]);
    end
    checks++; if (obs_d_q.size() != 2) begin errors++; $display("FAIL sim_count got %0d want 2", obs_d_q.size()); end
    while (obs_d_q.size() > 0 && exp_d_q.size() > 0) begin
      od = obs_d_q.pop_front(); ow = obs_w_q.pop_front();
      ed = exp_d_q.pop_front(); ew = exp_w_q.pop_front();
      checks++; if (od !== ed || ow !== ew) begin
        errors++; $display("FAIL sim_vec got %h/%h want %h/%h", od, ow, ed, ew);
      end
    end
    obs_d_q.delete(); obs_w_q.delete(); exp_d_q.delete(); exp_w_q.delete();
  endtask

  task automatic test_enable();
    bit ok;
    int n = 0;
    logic [VDW-1:0] ed, od;
    logic [VWW-1:0] ew, ow;
    res_delay = 12;
    for (int i = 0; i < 8; i++) send_pair(DW'($urandom), WW'($urandom), 1'b0);
    while (!data_valid && n < 50) begin @(negedge clk); n++; end
    enable = 1'b0;
    while (vectors_issued !== 16'(exp_issued + 1) && n < 200) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    checks++; if (n >= 200 || data_valid !== 1'b0 || fill_level !== 2'd1 || obs_d_q.size() != 1) begin
      errors++; $display("FAIL en_hold got n=%0d dv=%b fill=%0d issues=%0d want dv=0 fill=1 issues=1",
                         n, data_valid, fill_level, obs_d_q.size());
    end
    enable = 1'b1;
    exp_issued += 2;
    wait_idle(ok);
    checks++; if (!ok || vectors_issued !== exp_issued[15:0]) begin
      errors++; $display("FAIL en_resume got idle=%b issued=%0d want 1/%0d", ok, vectors_issued, exp_issued[15:0]);
    end
    while (obs_d_q.size() > 0 && exp_d_q.size() > 0) begin
      od = obs_d_q.pop_front(); ow = obs_w_q.pop_front();
      ed = exp_d_q.pop_front(); ew = exp_w_q.pop_front();
      checks++; if (od !== ed || ow !== ew) begin
        errors++; $display("FAIL en_vec got %h/%h want %h/%h", od, ow, ed, ew);
      end
    end
    obs_d_q.delete(); obs_w_q.delete(); exp_d_q.delete(); exp_w_q.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    int n = 0;
    logic [VDW-1:0] ed, od;
    logic [VWW-1:0] ew, ow;
    res_delay = 0;
    for (int i = 0; i < 4; i++) send_pair(DW'($urandom), WW'($urandom), 1'b0);
    while (timeout_err !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b want 1", timeout_err); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_idle got busy want idle"); end
    checks++; if (last_wait_len !== int'(TMO)) begin
      errors++; $display("FAIL tmo_wait_len got %0d want %0d", last_wait_len, TMO);
    end
    checks++; if (vectors_issued !== exp_issued[15:0]) begin
      errors++; $display("FAIL tmo_issued got %0d want %0d", vectors_issued, exp_issued[15:0]);
    end
    res_delay = 6;
    send_pair(DW'($urandom), WW'($urandom), 1'b0);
    send_pair(DW'($urandom), WW'($urandom), 1'b1);
    exp_issued++;
    wait_idle(ok);
    checks++; if (!ok || vectors_issued !== exp_issued[15:0]) begin
      errors++; $display("FAIL tmo_next got idle=%b issued=%0d want 1/%0d", ok, vectors_issued, exp_issued[15:0]);
    end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b want 1", timeout_err); end
    checks++; if (obs_d_q.size() != 2) begin errors++; $display("FAIL tmo_count got %0d want 2", obs_d_q.size()); end
    while (obs_d_q.size() > 0 && exp_d_q.size() > 0) begin
      od = obs_d_q.pop_front(); ow = obs_w_q.pop_front();
      ed = exp_d_q.pop_front(); ew = exp_w_q.pop_front();
      checks++; if (od !== ed || ow !== ew) begin
        errors++; $display("FAIL tmo_vec got %h/%h want %h/%h", od, ow, ed, ew);
      end
    end
    obs_d_q.delete(); obs_w_q.delete(); exp_d_q.delete(); exp_w_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    logic [VDW-1:0] ed, od;
    logic [VWW-1:0] ew, ow;
    res_delay = 40;
    for (int i = 0; i < 8; i++) send_pair(DW'($urandom), WW'($urandom), 1'b0);
    while (!(fill_level == 2'd2 && data_valid && !simd_start) && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL rm_setup got fill=%0d want 2 in wait", fill_level); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (data_valid !== 1'b0 || simd_start !== 1'b0 || vec_data_out !== '0 || vec_weight_out !== '0) begin
      errors++; $display("FAIL rm_outputs got dv=%b start=%b vec=%h/%h want all 0",
                         data_valid, simd_start, vec_data_out, vec_weight_out);
    end
    checks++; if (fill_level !== 2'd0 || vectors_issued !== 16'd0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL rm_state got fill=%0d issued=%0d tmo=%b want 0/0/0",
                         fill_level, vectors_issued, timeout_err);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    exp_d_q.delete(); exp_w_q.delete(); obs_d_q.delete(); obs_w_q.delete();
    cur_d = '0; cur_w = '0; cur_lane = 0; exp_issued = 0;
    res_delay = 6;
    for (int i = 0; i < 3; i++) send_pair(DW'($urandom), WW'($urandom), (i == 2));
    exp_issued++;
    wait_idle(ok);
    checks++; if (!ok || vectors_issued !== exp_issued[15:0]) begin
      errors++; $display("FAIL rm_recover got idle=%b issued=%0d want 1/%0d", ok, vectors_issued, exp_issued[15:0]);
    end
    checks++; if (obs_d_q.size() != 1) begin errors++; $display("FAIL rm_count got %0d want 1", obs_d_q.size()); end
    while (obs_d_q.size() > 0 && exp_d_q.size() > 0) begin
      od = obs_d_q.pop_front(); ow = obs_w_q.pop_front();
      ed = exp_d_q.pop_front(); ew = exp_w_q.pop_front();
      checks++; if (od !== ed || ow !== ew) begin
        errors++; $display("FAIL rm_vec got %h/%h want %h/%h", od, ow, ed, ew);
      end
    end
    checks++; if (zero_viol !== 0) begin errors++; $display("FAIL vec_zero_when_idle got %0d want 0", zero_viol); end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL vec_stable got %0d want 0", stab_viol); end
    checks++; if (drv_timeouts !== 0) begin errors++; $display("FAIL drv_stall got %0d want 0", drv_timeouts); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_partial();
    test_simultaneous();
    test_enable();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
